fir_bank_param: RTL and testbench

Parametrised multi-channel FIR filter bank. It is the successor to the fixed 8-channel, 128-tap, 2-sample-per-cycle bank. It shares one sample history across NCH channels and computes NTAPS-tap dot products with LANES multiply-accumulates per channel per cycle. It adds a ready/overrun handshake and round-and-saturate output scaling, and sits between the ADC sample front end and the per-band detectors.

---
 rtl/fir_bank_pkg.sv | 51 +++++
 rtl/fir_bank_chan.sv | 69 ++++++
 rtl/fir_bank_param.sv | 161 ++++++++++++++++
 tb/tb_fir_bank_param.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_bank_pkg.sv
// Shared state type and arithmetic helpers for the parametrised FIR filter bank.
package fir_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MAC   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Working width of round_sat; any accumulator is sign-extended to this first.
    localparam int RSW = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int accw(input int dw, input int cw, input int ntaps);
        return dw + cw + clog2(ntaps);
    endfunction

    // Round half up by 2^(oshift-1), arithmetic shift, then clamp to dw signed bits.
    function automatic logic signed [RSW-1:0] round_sat(input logic signed [RSW-1:0] acc,
                                                        input int oshift, input int dw);
        logic signed [RSW-1:0] t;
        logic signed [RSW-1:0] hi;
        logic signed [RSW-1:0] lo;
        t = acc;
        if (oshift > 0) begin
            t = acc + (64'sd1 <<< (oshift - 1));
        end
        t  = t >>> oshift;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (t > hi) begin
            return hi;
        end else if (t < lo) begin
            return lo;
        end else begin
            return t;
        end
    endfunction

endpackage

// File: rtl/fir_bank_chan.sv
// One channel of the bank: LANES signed multipliers, accumulator and output scaling.
module fir_bank_chan
    import fir_bank_pkg::*;
#(
    parameter int DW     = 16,
    parameter int CW     = 18,
    parameter int NTAPS  = 128,
    parameter int LANES  = 2,
    parameter int OSHIFT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  acc_en_i,
    input  logic                  done_i,
    input  logic [LANES*DW-1:0]   samp_i,
    input  logic [LANES*CW-1:0]   coef_i,
    output logic [DW-1:0]         dout_o
);

    localparam int ACCW = accw(DW, CW, NTAPS);
    localparam int PW   = DW + CW;

    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] sum_s;
    logic [DW-1:0]          dout_q;
    logic [DW-1:0]          dout_d;

    // Sum of this cycle's full-width lane products.
    always_comb begin
        sum_s = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_s = sum_s + ACCW'(PW'($signed(samp_i[l*DW +: DW])) * PW'($signed(coef_i[l*CW +: CW])));
        end
    end

    // Accumulator next state and scaled result; the last group is folded in at done.
    always_comb begin
        acc_d  = acc_q;
        dout_d = dout_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_q + sum_s;
        end else begin
            acc_d = acc_q;
        end
        if (done_i) begin
            dout_d = DW'(round_sat(RSW'(acc_q + sum_s), OSHIFT, DW));
        end else begin
            dout_d = dout_q;
        end
    end

    // Accumulator and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q  <= '0;
            dout_q <= '0;
        end else begin
            acc_q  <= acc_d;
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/fir_bank_param.sv
// Multi-channel FIR bank sharing one sample history; LANES taps per channel per cycle
// with ready/overrun handshake and round-and-saturate outputs.
module fir_bank_param
    import fir_bank_pkg::*;
#(
    parameter int DW     = 16,
    parameter int CW     = 18,
    parameter int NTAPS  = 128,
    parameter int NCH    = 8,
    parameter int LANES  = 2,
    parameter int OSHIFT = 16,
    localparam int AW    = (clog2(NTAPS / LANES) > 0) ? clog2(NTAPS / LANES) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DW-1:0]             datain,
    input  logic                      din_enable,
    output logic                      ready,
    output logic [AW-1:0]             coeffaddress,
    input  logic [NCH*LANES*CW-1:0]   coeff,
    output logic [NCH*DW-1:0]         dataout,
    output logic                      dout_valid,
    output logic                      overrun,
    input  logic                      clear_overrun
);

    localparam int NITER = NTAPS / LANES;
    localparam int TW    = (clog2(NTAPS) > 0) ? clog2(NTAPS) : 1;

    state_t                    state_q, state_d;
    logic [AW-1:0]             cnt_q, cnt_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic                      ready_q, ready_d;
    logic                      valid_q, valid_d;
    logic                      ovr_q, ovr_d;
    logic [LANES*DW-1:0]       grp_q, grp_d;
    logic [NCH*LANES*CW-1:0]   coef_q;
    logic [DW-1:0]             hist_q [NTAPS];
    logic                      accept_s, drop_s;
    logic                      clear_s, acc_en_s, done_s;

    // Next state, address sequencing, handshake and sample-group selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        grp_d    = grp_q;
        accept_s = din_enable && (state_q == IDLE);
        drop_s   = din_enable && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                addr_d = '0;
                if (din_enable) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                state_d = MAC;
                cnt_d   = '0;
                addr_d  = AW'(1);
            end
            MAC: begin
                addr_d = addr_q + AW'(1);
                for (int l = 0; l < LANES; l++) begin
                    grp_d[l*DW +: DW] = hist_q[TW'(LANES * int'(cnt_q) + l)];
                end
                if (cnt_q == AW'(NITER - 1)) begin
                    state_d = DONE;
                    cnt_d   = cnt_q;
                end else begin
                    state_d = MAC;
                    cnt_d   = cnt_q + AW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                addr_d  = '0;
            end
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_q == DONE);
        if (drop_s) begin
            ovr_d = 1'b1;
        end else if (clear_overrun) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Group 0 is only registered in MAC 0, so accumulation starts one MAC cycle later.
    assign clear_s  = (state_q == FETCH);
    assign acc_en_s = (state_q == MAC) && (cnt_q != '0);
    assign done_s   = (state_q == DONE);

    // Control, handshake and operand-alignment registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            grp_q   <= '0;
            coef_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            grp_q   <= grp_d;
            coef_q  <= coeff;
        end
    end

    // Sample history: shifts only when a strobe is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                hist_q[i] <= '0;
            end
        end else if (accept_s) begin
            hist_q[0] <= datain;
            for (int i = 1; i < NTAPS; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        fir_bank_chan #(
            .DW(DW), .CW(CW), .NTAPS(NTAPS), .LANES(LANES), .OSHIFT(OSHIFT)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .clear_i (clear_s),
            .acc_en_i(acc_en_s),
            .done_i  (done_s),
            .samp_i  (grp_q),
            .coef_i  (coef_q[c*LANES*CW +: LANES*CW]),
            .dout_o  (dataout[c*DW +: DW])
        );
    end

    assign ready        = ready_q;
    assign coeffaddress = addr_q;
    assign dout_valid   = valid_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_fir_bank_param.sv
// Bench for fir_bank_param: a default bank and an NCH=3/LANES=4/NTAPS=32 bank, each
// compared every cycle against a plain tap-sum model, plus literal spot checks.
module tb_fir_bank_param;

    localparam int DW   = 16;
    localparam int CW   = 18;
    localparam int N0   = 8;
    localparam int T0   = 128;
    localparam int L0   = 2;
    localparam int N1   = 3;
    localparam int T1   = 32;
    localparam int L1   = 4;
    localparam int CF0W = N0 * L0 * CW;
    localparam int CF1W = N1 * L1 * CW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [DW-1:0] din0 = '0;
    logic [DW-1:0] din1 = '0;
    logic en0 = 1'b0, en1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;
    logic rdy0, rdy1, dv0, dv1, ov0, ov1;
    logic [5:0] addr0;
    logic [2:0] addr1;
    logic [CF0W-1:0] cf0 = '0;
    logic [CF1W-1:0] cf1 = '0;
    logic [N0*DW-1:0] dout0;
    logic [N1*DW-1:0] dout1;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int nch_of[2]   = '{N0, N1};
    int ntaps_of[2] = '{T0, T1};
    int lanes_of[2] = '{L0, L1};

    int hist [2][T0];
    int coef [2][N0][T0];
    logic [127:0] heldv[2];
    logic [127:0] pend_vals[2];
    bit pending[2];
    int due[2];
    int busy_until[2];
    bit ovm[2];
    bit chk_en[2];

    fir_bank_param #(.DW(DW), .CW(CW), .NTAPS(T0), .NCH(N0), .LANES(L0), .OSHIFT(16)) dut0 (
        .clock(clock), .reset(reset), .datain(din0), .din_enable(en0), .ready(rdy0),
        .coeffaddress(addr0), .coeff(cf0), .dataout(dout0), .dout_valid(dv0),
        .overrun(ov0), .clear_overrun(clr0));

    fir_bank_param #(.DW(DW), .CW(CW), .NTAPS(T1), .NCH(N1), .LANES(L1), .OSHIFT(16)) dut1 (
        .clock(clock), .reset(reset), .datain(din1), .din_enable(en1), .ready(rdy1),
        .coeffaddress(addr1), .coeff(cf1), .dataout(dout1), .dout_valid(dv1),
        .overrun(ov1), .clear_overrun(clr1));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Coefficient memory with one cycle of read latency: lane l of group a is tap lanes*a+l.
    function automatic logic [287:0] pack(input int d, input int a);
        logic [287:0] r;
        int idx;
        r = '0;
        for (int c = 0; c < nch_of[d]; c++) begin
            for (int l = 0; l < lanes_of[d]; l++) begin
                idx = lanes_of[d] * a + l;
                if (idx < ntaps_of[d]) r[(c*lanes_of[d]+l)*CW +: CW] = CW'(coef[d][c][idx]);
            end
        end
        return r;
    endfunction

    always @(posedge clock) cf0 <= CF0W'(pack(0, int'(addr0)));
    always @(posedge clock) cf1 <= CF1W'(pack(1, int'(addr1)));

    // Reference output: full tap sum, round half up at bit 15, shift 16, clamp to 16 bits.
    function automatic logic [127:0] model_out(input int d);
        logic [127:0] r;
        longint acc;
        longint y;
        r = '0;
        for (int c = 0; c < nch_of[d]; c++) begin
            acc = 0;
            for (int t = 0; t < ntaps_of[d]; t++) acc += longint'(hist[d][t]) * longint'(coef[d][c][t]);
            y = (acc + 64'sd32768) >>> 16;
            if (y > 32767) y = 32767;
            else if (y < -32768) y = -32768;
            r[c*DW +: DW] = y[DW-1:0];
        end
        return r;
    endfunction

    task automatic check(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", name, d, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int d, input logic rst, input logic en, input logic clr,
                              input logic [DW-1:0] din, input logic a_dv, input logic a_rdy,
                              input logic a_ov, input logic [127:0] a_dout);
        logic e_dv;
        logic e_rdy;
        int niter;
        niter = ntaps_of[d] / lanes_of[d];
        e_dv  = pending[d] && (due[d] == cyc);
        if (e_dv) begin
            heldv[d]   = pend_vals[d];
            pending[d] = 1'b0;
        end
        e_rdy = (cyc > busy_until[d]);
        if (chk_en[d]) begin
            check("dout_valid", d, 128'(a_dv), 128'(e_dv));
            check("ready", d, 128'(a_rdy), 128'(e_rdy));
            check("overrun", d, 128'(a_ov), 128'(ovm[d]));
            check("dataout", d, a_dout, heldv[d]);
        end
        if (rst) begin
            for (int t = 0; t < T0; t++) hist[d][t] = 0;
            pending[d]    = 1'b0;
            busy_until[d] = cyc;
            ovm[d]        = 1'b0;
            heldv[d]      = '0;
            chk_en[d]     = 1'b1;
        end else begin
            if (en && e_rdy) begin
                for (int t = T0 - 1; t > 0; t--) hist[d][t] = hist[d][t-1];
                hist[d][0]    = int'($signed(din));
                pend_vals[d]  = model_out(d);
                pending[d]    = 1'b1;
                due[d]        = cyc + niter + 3;
                busy_until[d] = cyc + niter + 2;
            end
            if (en && !e_rdy) ovm[d] = 1'b1;
            else if (clr) ovm[d] = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            model_step(0, reset, en0, clr0, din0, dv0, rdy0, ov0, 128'(dout0));
            model_step(1, reset, en1, clr1, din1, dv1, rdy1, ov1, 128'(dout1));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int d, input logic en, input logic [DW-1:0] v, input logic clr);
        if (d == 0) begin
            en0 = en; din0 = v; clr0 = clr;
        end else begin
            en1 = en; din1 = v; clr1 = clr;
        end
    endtask

    task automatic send(input int d, input logic [DW-1:0] v, output int at);
        drive(d, 1'b1, v, 1'b0);
        at = cyc;
        tick();
        drive(d, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_dv(input int d, output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            if ((d == 0) ? dv0 : dv1) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL dv_timeout dut%0d cyc=%0d actual=none required=dout_valid", d, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic int rand_coef();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    task automatic rand_coefs(input int d);
        for (int c = 0; c < N0; c++)
            for (int t = 0; t < T0; t++) coef[d][c][t] = rand_coef();
    endtask

    initial begin
        int c0;
        int at;
        tick();
        tick();
        reset = 1'b0;

        // Impulse, default bank: 0x4000 * 4t >> 16 makes the k-th output equal k.
        for (int c = 0; c < N0; c++)
            for (int t = 0; t < T0; t++) begin
                coef[0][c][t] = 4 * t;
                coef[1][c][t] = 4 * t;
            end
        send(0, 16'h4000, c0);
        check("ready_fall", 0, 128'(rdy0), 128'd0);
        for (int k = 0; k < T0; k++) begin
            wait_dv(0, at);
            check("latency", 0, 128'(at - c0), 128'd67);
            check("ready_at_dv", 0, 128'(rdy0), 128'd1);
            check("impulse", 0, 128'(dout0), 128'({N0{DW'(k)}}));
            if (k < T0 - 1) send(0, '0, c0);
        end

        // Impulse, small bank.
        send(1, 16'h4000, c0);
        for (int k = 0; k < T1; k++) begin
            wait_dv(1, at);
            check("latency", 1, 128'(at - c0), 128'd11);
            check("impulse", 1, 128'(dout1), 128'({N1{DW'(k)}}));
            if (k < T1 - 1) send(1, '0, c0);
        end

        // Saturation and rounding with history x0=1, x1=0x7FFF.
        do_reset();
        for (int c = 0; c < N0; c++)
            for (int t = 0; t < T0; t++) coef[0][c][t] = (c >= 6) ? rand_coef() : 0;
        coef[0][0][1] = 131071;
        coef[0][1][1] = -131071;
        coef[0][2][0] = 98304;
        coef[0][3][0] = -98304;
        for (int t = 0; t < T0; t++) begin
            coef[0][4][t] = 131071;
            coef[0][5][t] = -131071;
        end
        send(0, 16'h7FFF, c0);
        wait_dv(0, at);
        send(0, 16'h0001, c0);
        wait_dv(0, at);
        check("sat_round", 0, 128'(dout0[95:0]), 128'h8000_7FFF_FFFF_0002_8000_7FFF);

        // Overrun: drop at +10, clear at +20, clear together with a drop at +30.
        rand_coefs(0);
        send(0, DW'($urandom), c0);
        while (cyc < c0 + 10) tick();
        check("ovr_before", 0, 128'(ov0), 128'd0);
        drive(0, 1'b1, DW'($urandom), 1'b0);
        tick();
        drive(0, 1'b0, '0, 1'b0);
        check("ovr_set", 0, 128'(ov0), 128'd1);
        while (cyc < c0 + 20) tick();
        drive(0, 1'b0, '0, 1'b1);
        tick();
        drive(0, 1'b0, '0, 1'b0);
        check("ovr_clear", 0, 128'(ov0), 128'd0);
        while (cyc < c0 + 30) tick();
        drive(0, 1'b1, DW'($urandom), 1'b1);
        tick();
        drive(0, 1'b0, '0, 1'b0);
        check("ovr_set_wins", 0, 128'(ov0), 128'd1);
        wait_dv(0, at);
        drive(0, 1'b0, '0, 1'b1);
        tick();
        drive(0, 1'b0, '0, 1'b0);

        // Reset in the middle of a computation.
        send(0, DW'($urandom), c0);
        while (cyc < c0 + 30) tick();
        do_reset();
        check("rst_ready", 0, 128'(rdy0), 128'd1);
        check("rst_dataout", 0, 128'(dout0), 128'd0);
        repeat (80) tick();
        send(0, DW'($urandom), c0);
        wait_dv(0, at);

        // Random traffic on both banks, including drops and clears.
        do_reset();
        rand_coefs(0);
        rand_coefs(1);
        repeat (4000) begin
            drive(0, ($urandom_range(0, 19) == 0), DW'($urandom), ($urandom_range(0, 9) == 0));
            drive(1, ($urandom_range(0, 5) == 0), DW'($urandom), ($urandom_range(0, 9) == 0));
            tick();
        end
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        repeat (80) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
